muldiv_sequencer: RTL

- Controls the multi-cycle multiply/divide unit attached to the Execute stage.
- Decodes the multi-cycle ALUControlE codes (MUL through SDIV) and pulses a start to the unit.
- Holds the F/D/E stages with a stall for a fixed, op-dependent latency.
- Signals when the result may advance into Memory; squashes the operation on a flush.
- Single-cycle ALU ops pass through untouched.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_decode.sv | 61 ++++++
 rtl/muldiv_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// ALU control codes, unit op codes and FSM states.
package muldiv_pkg;

  localparam logic [5:0] ALU_MUL   = 6'b100111;
  localparam logic [5:0] ALU_MLA   = 6'b101000;
  localparam logic [5:0] ALU_MLS   = 6'b101001;
  localparam logic [5:0] ALU_UMULL = 6'b101010;
  localparam logic [5:0] ALU_UMLAL = 6'b101011;
  localparam logic [5:0] ALU_SMULL = 6'b101100;
  localparam logic [5:0] ALU_SMLAL = 6'b101101;
  localparam logic [5:0] ALU_UDIV  = 6'b101110;
  localparam logic [5:0] ALU_SDIV  = 6'b101111;

  typedef enum logic [2:0] {
    MD_MUL   = 3'd0,
    MD_MLA   = 3'd1,
    MD_MLS   = 3'd2,
    MD_UMULL = 3'd3,
    MD_UMLAL = 3'd4,
    MD_SMULL = 3'd5,
    MD_SMLAL = 3'd6,
    MD_DIV   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> mul/div sequencer signal bundle. The master side is the
// pipeline (E stage + hazard unit); the slave side is the sequencer.
interface muldiv_sequencer_if;
  logic       OpValidE;
  logic [5:0] ALUControlE;
  logic       DivByZeroE;
  logic       FlushE;
  logic       MdStartE;
  logic [2:0] MdOpE;
  logic       MdSignedE;
  logic       MdWideE;
  logic       MdAbortE;
  logic       StallMd;
  logic       MdResultValid;
  logic       MdBusy;

  modport master (
    output OpValidE, ALUControlE, DivByZeroE, FlushE,
    input  MdStartE, MdOpE, MdSignedE, MdWideE, MdAbortE,
           StallMd, MdResultValid, MdBusy
  );

  modport slave (
    input  OpValidE, ALUControlE, DivByZeroE, FlushE,
    output MdStartE, MdOpE, MdSignedE, MdWideE, MdAbortE,
           StallMd, MdResultValid, MdBusy
  );
endinterface

// File: rtl/muldiv_decode.sv
// Combinational decode of ALU control codes into mul/div op attributes and
// the number of cycles the pipeline must stall for that op.
module muldiv_decode
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int MULL_LAT = 3,
  parameter int DIV_LAT  = 33,
  parameter int CNT_W    = 6
) (
  input  logic [5:0]       alu_control,
  input  logic             div_by_zero,
  output logic             is_multicycle,
  output md_op_e           md_op,
  output logic             md_signed,
  output logic             md_wide,
  output logic [CNT_W-1:0] latency
);

  localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] LAT_MULL = CNT_W'(MULL_LAT);
  localparam logic [CNT_W-1:0] LAT_DIV  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] LAT_ONE  = CNT_W'(1);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    is_multicycle = 1'b0;
    md_op         = MD_MUL;
    md_signed     = 1'b0;
    md_wide       = 1'b0;
    latency       = '0;
    case (alu_control)
      ALU_MUL:   begin is_multicycle = 1'b1; md_op = MD_MUL; latency = LAT_MUL; end
      ALU_MLA:   begin is_multicycle = 1'b1; md_op = MD_MLA; latency = LAT_MUL; end
      ALU_MLS:   begin is_multicycle = 1'b1; md_op = MD_MLS; latency = LAT_MUL; end
      ALU_UMULL: begin
        is_multicycle = 1'b1; md_op = MD_UMULL; md_wide = 1'b1; latency = LAT_MULL;
      end
      ALU_UMLAL: begin
        is_multicycle = 1'b1; md_op = MD_UMLAL; md_wide = 1'b1; latency = LAT_MULL;
      end
      ALU_SMULL: begin
        is_multicycle = 1'b1; md_op = MD_SMULL; md_wide = 1'b1; md_signed = 1'b1;
        latency = LAT_MULL;
      end
      ALU_SMLAL: begin
        is_multicycle = 1'b1; md_op = MD_SMLAL; md_wide = 1'b1; md_signed = 1'b1;
        latency = LAT_MULL;
      end
      // Divide by zero short-circuits: the unit returns 0 after a single cycle.
      ALU_UDIV, ALU_SDIV: begin
        is_multicycle = 1'b1;
        md_op         = MD_DIV;
        md_signed     = (alu_control == ALU_SDIV);
        latency       = div_by_zero ? LAT_ONE : LAT_DIV;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues multi-cycle mul/div ops from E, stalls F/D/E for the op latency,
// flags the cycle the result may move to M, and aborts the op on a flush.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int MULL_LAT = 3,
  parameter int DIV_LAT  = 33,
  parameter int CNT_W    = 6
) (
  input logic                clk,
  input logic                reset,
  muldiv_sequencer_if.slave  bus
);

  logic             dec_mc;
  md_op_e           dec_op;
  logic             dec_signed;
  logic             dec_wide;
  logic [CNT_W-1:0] dec_lat;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q;
  logic             signed_q;
  logic             wide_q;
  logic             issue;

  muldiv_decode #(
    .MUL_LAT  (MUL_LAT),
    .MULL_LAT (MULL_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_decode (
    .alu_control   (bus.ALUControlE),
    .div_by_zero   (bus.DivByZeroE),
    .is_multicycle (dec_mc),
    .md_op         (dec_op),
    .md_signed     (dec_signed),
    .md_wide       (dec_wide),
    .latency       (dec_lat)
  );

  // Qualifying with reset keeps the combinational start/stall quiet while reset is held.
  assign issue = reset && (state_q == ST_IDLE) && bus.OpValidE && dec_mc && !bus.FlushE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      signed_q <= 1'b0;
      wide_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        op_q     <= dec_op;
        signed_q <= dec_signed;
        wide_q   <= dec_wide;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    bus.MdStartE       = 1'b0;
    bus.StallMd        = 1'b0;
    bus.MdResultValid  = 1'b0;
    bus.MdAbortE       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          bus.MdStartE = 1'b1;
          bus.StallMd  = 1'b1;
          if (dec_lat == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = dec_lat - CNT_W'(1);
          end
        end
      end
      ST_BUSY: begin
        bus.StallMd = 1'b1;
        if (bus.FlushE) begin
          bus.MdAbortE = 1'b1;
          state_d      = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Always return to IDLE so the still-present E instruction is not re-issued.
      ST_DONE: begin
        bus.MdAbortE      = bus.FlushE;
        bus.MdResultValid = !bus.FlushE;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.MdOpE     = op_q;
  assign bus.MdSignedE = signed_q;
  assign bus.MdWideE   = wide_q;
  assign bus.MdBusy    = (state_q != ST_IDLE);

endmodule
